// File: rtl/snes_controller_reader.sv
// SNES controller poller: drives latch/clock, shifts in 16 button bits, and
// publishes the completed frame atomically as an active-high word.
module snes_controller_reader #(
  parameter int unsigned HALF_PERIOD = 300,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snesData,
  output logic        snesLatch,
  output logic        snesClock,
  output logic [15:0] snesInput,
  output logic        newSample
);

  localparam int unsigned POLL_W  = $clog2(POLL_PERIOD);
  localparam int unsigned PHASE_W = $clog2(2 * HALF_PERIOD);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_HIGH, CLK_LOW, DONE} stateType;

  stateType             state, stateNext;
  logic [POLL_W-1:0]    pollCnt;
  logic [PHASE_W-1:0]   phaseCnt;
  logic [3:0]           bitIdx, bitIdxNext;
  logic [15:0]          shift, shiftNext;
  logic                 syncMeta, syncData;
  logic                 pollWrap, halfDone, latchDone;

  assign pollWrap  = (pollCnt == POLL_W'(POLL_PERIOD - 1));
  assign halfDone  = (phaseCnt == PHASE_W'(HALF_PERIOD - 1));
  assign latchDone = (phaseCnt == PHASE_W'(2 * HALF_PERIOD - 1));

  // Two-flop synchroniser; idles high like a released line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta <= 1'b1;
      syncData <= 1'b1;
    end else begin
      syncMeta <= snesData;
      syncData <= syncMeta;
    end
  end

  // Free-running poll interval counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pollCnt <= '0;
    end else if (pollWrap) begin
      pollCnt <= '0;
    end else begin
      pollCnt <= pollCnt + POLL_W'(1);
    end
  end

  // State, per-state phase counter, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phaseCnt  <= '0;
      bitIdx    <= '0;
      shift     <= '0;
      snesLatch <= 1'b0;
      snesClock <= 1'b1;
      newSample <= 1'b0;
      snesInput <= '0;
    end else begin
      state     <= stateNext;
      phaseCnt  <= (stateNext != state) ? '0 : phaseCnt + PHASE_W'(1);
      bitIdx    <= bitIdxNext;
      shift     <= shiftNext;
      // Outputs decoded from the next state so they align with the state itself
      snesLatch <= (stateNext == LATCH);
      snesClock <= (stateNext != CLK_LOW);
      newSample <= (stateNext == DONE);
      if (stateNext == DONE) begin
        snesInput <= shiftNext;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    shiftNext  = shift;
    case (state)
      IDLE: begin
        if (pollWrap) stateNext = LATCH;
      end
      LATCH: begin
        if (latchDone) begin
          stateNext  = CLK_HIGH;
          bitIdxNext = '0;
        end
      end
      CLK_HIGH: begin
        if (halfDone) begin
          shiftNext[bitIdx] = ~syncData;
          bitIdxNext        = bitIdx + 4'd1;
          stateNext         = (bitIdx == 4'd15) ? DONE : CLK_LOW;
        end
      end
      CLK_LOW: begin
        if (halfDone) stateNext = CLK_HIGH;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_snes_controller_reader.sv
// Directed bench for snes_controller_reader with a behavioural SNES pad model.
module tb_snes_controller_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        snesData;
  logic        snesLatch;
  logic        snesClock;
  logic [15:0] snesInput;
  logic        newSample;

  logic [15:0] padWord = 16'h0000;
  logic [4:0]  padIdx = 5'd16;
  logic        modelData;
  logic        ovEn = 1'b0;
  logic        ovVal = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc, lat, low, bad, falls;
  bit seen;
  logic prevClk;

  snes_controller_reader #(.HALF_PERIOD(4), .POLL_PERIOD(200)) dut (
    .clk(clk),
    .rst(rst),
    .snesData(snesData),
    .snesLatch(snesLatch),
    .snesClock(snesClock),
    .snesInput(snesInput),
    .newSample(newSample)
  );

  always #5 clk = ~clk;

  // Pad model: latch reloads bit 0, each rising serial clock advances one bit
  always @(posedge snesLatch or posedge snesClock) begin
    if (snesLatch) padIdx <= 5'd0;
    else if (padIdx < 5'd16) padIdx <= padIdx + 5'd1;
  end

  always_comb begin
    modelData = 1'b1;
    if (padIdx < 5'd16) modelData = ~padWord[padIdx[3:0]];
  end

  assign snesData = ovEn ? ovVal : modelData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitSample(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (newSample) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic waitLatch(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (snesLatch) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic measureFrame(output int latchCycles, output int lowPulses,
                              output int badLow, output int cycles);
    int lowRun;
    latchCycles = 0;
    lowPulses   = 0;
    badLow      = 0;
    cycles      = -1;
    lowRun      = 0;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (snesLatch) latchCycles++;
      if (!snesClock) begin
        lowRun++;
      end else if (lowRun != 0) begin
        lowPulses++;
        if (lowRun != 4) badLow++;
        lowRun = 0;
      end
      if (newSample) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_latch", 32'(snesLatch), 32'd0);
    check("rst_clock", 32'(snesClock), 32'd1);
    check("rst_input", 32'(snesInput), 32'h0000);
    check("rst_newSample", 32'(newSample), 32'd0);
    rst = 1'b0;

    // 1: released line; frame shape and poll interval
    waitSample(400, cyc);
    check("first_latency", 32'(cyc), 32'd332);
    check("idle_word", 32'(snesInput), 32'h0000);
    measureFrame(lat, low, bad, cyc);
    check("latch_width", 32'(lat), 32'd8);
    check("clock_low_pulses", 32'(low), 32'd15);
    check("clock_low_width_bad", 32'(bad), 32'd0);
    check("poll_interval", 32'(cyc), 32'd200);
    check("released_word", 32'(snesInput), 32'h0000);

    // 2: B and Start
    padWord = 16'h0009;
    waitSample(250, cyc);
    check("interval_2", 32'(cyc), 32'd200);
    check("b_start_word", 32'(snesInput), 32'h0009);
    @(negedge clk);
    check("pulse_one_cycle", 32'(newSample), 32'd0);
    check("word_held_after", 32'(snesInput), 32'h0009);

    // 3: all twelve buttons, then upper bits stored as read
    padWord = 16'h0FFF;
    waitSample(250, cyc);
    check("all_buttons_word", 32'(snesInput), 32'h0FFF);
    padWord = 16'hA005;
    waitSample(250, cyc);
    check("upper_bits_word", 32'(snesInput), 32'hA005);

    // 4: atomic update across a mid-frame change
    padWord = 16'h0100;
    waitSample(250, cyc);
    check("a_word", 32'(snesInput), 32'h0100);
    waitLatch(250, seen);
    check("frame2_latch_seen", 32'(seen), 32'd1);
    repeat (20) @(negedge clk);
    padWord = 16'h0000;
    check("hold_early", 32'(snesInput), 32'h0100);
    repeat (60) @(negedge clk);
    check("hold_late", 32'(snesInput), 32'h0100);
    check("no_pulse_mid", 32'(newSample), 32'd0);
    waitSample(250, cyc);
    check("frame2_word", 32'(snesInput), 32'h0000);

    // 5: reset during CLK_LOW after bit 7
    padWord = 16'h0009;
    waitSample(250, cyc);
    check("pre_reset_word", 32'(snesInput), 32'h0009);
    waitLatch(250, seen);
    check("frame_latch_seen", 32'(seen), 32'd1);
    falls = 0;
    prevClk = snesClock;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prevClk && !snesClock) falls++;
      prevClk = snesClock;
      if (falls == 8) break;
    end
    check("clock_falls", 32'(falls), 32'd8);
    check("clock_low_before_rst", 32'(snesClock), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_latch", 32'(snesLatch), 32'd0);
    check("midrst_clock", 32'(snesClock), 32'd1);
    check("midrst_input", 32'(snesInput), 32'h0000);
    check("midrst_newSample", 32'(newSample), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    waitSample(400, cyc);
    check("post_rst_latency", 32'(cyc), 32'd332);
    check("post_rst_word", 32'(snesInput), 32'h0009);

    // 6: asynchronous toggles around the bit 5 and bit 6 sample points
    padWord = 16'h0040;
    waitLatch(250, seen);
    check("async_latch_seen", 32'(seen), 32'd1);
    #488 ovEn = 1'b1; ovVal = 1'b0;
    #14  ovVal = 1'b1;
    #6   ovVal = 1'b0;
    #60  ovVal = 1'b1;
    #14  ovVal = 1'b0;
    #26  ovEn = 1'b0;
    waitSample(250, cyc);
    check("async_sample_seen", 32'(cyc > 0), 32'd1);
    check("async_word", 32'(snesInput), 32'h0020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
